// File: rtl/run_zero_detector_if.sv
// Serial-line bundle for the run-of-ones zero detector.
// master drives the sample stream, slave is the detector.
interface run_zero_detector_if #(
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
);
  logic             en;
  logic             x_in;
  logic             clr_evt;
  logic             y_out;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] cur_run;
  logic             sat;
  logic [EVT_W-1:0] evt_cnt;

  modport master (
    output en, x_in, clr_evt,
    input  y_out, run_len, cur_run, sat, evt_cnt
  );

  modport slave (
    input  en, x_in, clr_evt,
    output y_out, run_len, cur_run, sat, evt_cnt
  );
endinterface

// File: rtl/run_zero_detector.sv
// Flags a 0 that ends a run of >= MIN_RUN ones, reports the
// run length and counts detections. Mealy or registered outputs.
module run_zero_detector #(
  parameter int CNT_W      = 4,
  parameter int MIN_RUN    = 1,
  parameter int REGISTERED = 0,
  parameter int EVT_W      = 8
) (
  input logic               clock,
  input logic               reset,
  run_zero_detector_if.slave bus
);

  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("run_zero_detector: CNT_W out of range");
  end
  if (MIN_RUN < 1 || MIN_RUN > (2**CNT_W) - 1) begin : g_bad_min
    $error("run_zero_detector: MIN_RUN out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SAT
  } state_t;

  localparam logic [CNT_W-1:0] MAX  = '1;
  localparam logic [CNT_W-1:0] MINV = CNT_W'(MIN_RUN);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cur_run;
  logic [CNT_W-1:0] nxt_run;
  logic [EVT_W-1:0] evt_cnt;
  logic             det;
  logic [CNT_W-1:0] det_len;

  assign nxt_run = cur_run + ONE;
  assign det     = bus.en & ~bus.x_in & (cur_run >= MINV);
  assign det_len = det ? cur_run : '0;

  // Run-length FSM with saturating count and the event counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cur_run <= '0;
      evt_cnt <= '0;
    end else begin
      if (bus.en) begin
        if (!bus.x_in) begin
          state   <= IDLE;
          cur_run <= '0;
        end else begin
          unique case (1'b1)
            (state == IDLE): begin
              cur_run <= ONE;
              state   <= (ONE == MAX) ? SAT : RUN;
            end
            (state == RUN): begin
              cur_run <= nxt_run;
              state   <= (nxt_run == MAX) ? SAT : RUN;
            end
            (state == SAT): begin
              cur_run <= MAX;
              state   <= SAT;
            end
            default: begin
              cur_run <= '0;
              state   <= IDLE;
            end
          endcase
        end
      end
      if (bus.clr_evt) begin
        evt_cnt <= '0;
      end else if (det) begin
        evt_cnt <= evt_cnt + EVT_W'(1);
      end
    end
  end

  if (REGISTERED != 0) begin : g_reg
    logic             y_r;
    logic [CNT_W-1:0] len_r;

    // Detection pulse delayed one edge so x_in glitches never reach y_out
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        y_r   <= 1'b0;
        len_r <= '0;
      end else begin
        y_r   <= det;
        len_r <= det_len;
      end
    end

    assign bus.y_out   = y_r;
    assign bus.run_len = len_r;
  end else begin : g_mealy
    assign bus.y_out   = det;
    assign bus.run_len = det_len;
  end

  assign bus.cur_run = cur_run;
  assign bus.sat     = (cur_run == MAX);
  assign bus.evt_cnt = evt_cnt;

endmodule

// File: doc/run_zero_detector.md
# run_zero_detector

Parametrised Mealy/registered detector that flags a 0 on a serial input when it ends a run of at least MIN_RUN consecutive 1s. It also reports the length of the run that ended and keeps a count of detections. It is the generalised successor of the fixed 2-bit zero detector and sits on sampled serial lines in the sequential datapath. With CNT_W=2, MIN_RUN=1, REGISTERED=0 and en tied high, y_out matches the 2-bit detector cycle for cycle.

## Interface
- CNT_W, 4: width of the run-length counter. Legal range 2..16.
- MIN_RUN, 1: minimum run of 1s needed for detection. Legal range 1..2^CNT_W-1; elaboration error outside this range.
- REGISTERED, 0: output mode. 0 = Mealy (combinational from state and x_in); 1 = registered (outputs one cycle later, glitch-free).
- EVT_W, 8: width of the detection event counter.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; x_in is ignored when en=0.
- x_in  in  1  serial input bit.
- clr_evt  in  1  synchronous clear of evt_cnt.
- y_out  out  1  detection pulse.
- run_len  out  CNT_W  length of the terminated run, valid when y_out=1; 0 otherwise.
- cur_run  out  CNT_W  current consecutive-1 count, registered.
- sat  out  1  high while cur_run = 2^CNT_W-1.
- evt_cnt  out  EVT_W  number of detections, wrap-around.

## Operation
- FSM states:
  - IDLE: cur_run=0.
  - RUN: 0 < cur_run < max.
  - SAT: cur_run = max = 2^CNT_W-1.
- Transitions happen only on a clock edge with en=1:
  - IDLE, x=1 -> RUN with cur_run=1. If CNT_W would make 1 = max, go to SAT (not reachable for CNT_W≥2).
  - RUN, x=1 -> cur_run+1; go to SAT when the value reaches max.
  - SAT, x=1 -> stay in SAT; cur_run holds at max (saturates, never wraps).
  - Any state, x=0 -> IDLE with cur_run=0.
- en=0: state and cur_run hold; no detection.
- Detection condition: det = en & ~x_in & (cur_run >= MIN_RUN), evaluated on the current registered cur_run.
- REGISTERED=0:
  - y_out = det.
  - run_len = det ? cur_run : 0.
  - Both follow x_in and en within the same cycle.
- REGISTERED=1:
  - y_out and run_len are flops loaded each edge with det and (det ? cur_run : 0).
- evt_cnt:
  - Increments by 1 on each edge where det=1; wraps from 2^EVT_W-1 to 0.
  - clr_evt=1 sets it to 0 on that edge. If clr_evt and det occur on the same edge, clr_evt wins: result 0, the detection is not counted.
- sat = (cur_run == 2^CNT_W-1).

## Timing
- Reset (reset=0, asynchronous, immediate): state=IDLE, cur_run=0, sat=0, evt_cnt=0; registered y_out=0, run_len=0.
  - In Mealy mode y_out is also 0 during reset, because cur_run=0 < MIN_RUN.
- Reset release: first state update occurs on the first rising edge with reset=1.
- Mealy latency: 0 cycles from x_in to y_out. Registered latency: 1 cycle.
- A 0 that ends a detected run also resets the count. Therefore back-to-back 0s give exactly one y_out pulse, and the pattern 1,0,1,0 with MIN_RUN=1 gives two pulses.
- Reset asserted mid-run: cur_run is lost. A 0 arriving after reset release does not detect.
- cur_run and sat are always registered and are independent of REGISTERED.

## Test plan
- Reset/equivalence: CNT_W=2, MIN_RUN=1, Mealy, en=1. Drive x = 1,1,1,1,0.
  - cur_run = 1,2,3,3,0; sat high from the 3rd edge; y_out=1 only during the cycle x=0, with run_len=3; evt_cnt=1.
- Threshold: MIN_RUN=3. Drive x = 1,1,0 -> no pulse. Then x = 1,1,1,0 -> y_out=1, run_len=3. Then x = 0,0 -> no further pulses.
- Enable gating: start at cur_run=2, hold en=0 and drive x=0 for 3 cycles -> y_out=0 and cur_run stays 2. Then en=1 with x=0 -> pulse with run_len=2.
- Registered mode: REGISTERED=1, x = 1,1,0 -> y_out high during the cycle after the 0 is sampled, run_len=2. Glitches on x_in between edges must not appear on y_out.
- Counter wrap/clear: EVT_W=2, drive 5 detections -> evt_cnt = 1,2,3,0,1. Then assert clr_evt on the same edge as a detection -> evt_cnt=0.
- Async reset mid-run: at cur_run=5, pull reset low between edges -> all outputs 0 immediately. Release reset, then x=0 -> no pulse.
